// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control tracker: the per-stage control
// bundle, its bubble value and the ALUOp class encodings.
package pipe_pkg;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       RegWrite;
    logic       MemRead;
    logic [1:0] ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    valid:    1'b0,
    rs1:      5'd0,
    rs2:      5'd0,
    rd:       5'd0,
    RegWrite: 1'b0,
    MemRead:  1'b0,
    ALUOp:    ALUOP_ADD
  };

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register holding a ctrl_t bundle, with hold (freeze)
// taking priority over bubble insertion.
module pipe_stage_reg
  import pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_hold,
  input  logic  i_bubble,
  input  ctrl_t i_d,
  output ctrl_t o_q
);

  ctrl_t r_q;

  // NOTE: sequential state uses non-blocking assignments only; the async
  // reset is in the sensitivity list so outputs clear without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= CTRL_BUBBLE;
    end else if (i_hold) begin
      r_q <= r_q;
    end else if (i_bubble) begin
      r_q <= CTRL_BUBBLE;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_ctrl_track.sv
// Carries decoded register indices and control bits through ID/EX, EX/MEM and
// MEM/WB for forwarding/hazard logic, and counts retirements and stall bubbles.
module pipe_ctrl_track
  import pipe_pkg::*;
#(
  parameter int INSTRET_W = 32,
  parameter int STALL_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic [4:0]           id_rd,
  input  logic                 id_RegWrite,
  input  logic                 id_MemRead,
  input  logic [1:0]           id_ALUOp,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 freeze,
  output logic                 idex_valid,
  output logic [4:0]           idex_rs1,
  output logic [4:0]           idex_rs2,
  output logic [4:0]           idex_rd,
  output logic                 idex_MemRead,
  output logic                 idex_RegWrite,
  output logic [1:0]           idex_ALUOp,
  output logic                 exmem_valid,
  output logic [4:0]           exmem_rd,
  output logic                 exmem_RegWrite,
  output logic                 exmem_MemRead,
  output logic                 memwb_valid,
  output logic [4:0]           memwb_rd,
  output logic                 memwb_RegWrite,
  output logic [INSTRET_W-1:0] instret,
  output logic [STALL_W-1:0]   stall_cnt
);

  ctrl_t w_id_ctrl;
  ctrl_t w_idex;
  ctrl_t w_exmem;
  ctrl_t w_memwb_d;
  ctrl_t w_memwb;
  logic  w_idex_bubble;

  logic [INSTRET_W-1:0] r_instret;
  logic [STALL_W-1:0]   r_stall_cnt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_id_ctrl          = CTRL_BUBBLE;
    w_id_ctrl.valid    = 1'b1;
    w_id_ctrl.rs1      = id_rs1;
    w_id_ctrl.rs2      = id_rs2;
    w_id_ctrl.rd       = id_rd;
    // x0 is never a real write target; dropping it here keeps forwarding simple.
    w_id_ctrl.RegWrite = id_RegWrite & (id_rd != 5'd0);
    w_id_ctrl.MemRead  = id_MemRead;
    w_id_ctrl.ALUOp    = id_ALUOp;
  end

  assign w_idex_bubble = flush | stall | ~id_valid;

  always_comb begin
    w_memwb_d         = w_exmem;
    w_memwb_d.MemRead = 1'b0;
  end

  pipe_stage_reg u_idex (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (freeze),
    .i_bubble (w_idex_bubble),
    .i_d      (w_id_ctrl),
    .o_q      (w_idex)
  );

  pipe_stage_reg u_exmem (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (freeze),
    .i_bubble (1'b0),
    .i_d      (w_idex),
    .o_q      (w_exmem)
  );

  pipe_stage_reg u_memwb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (freeze),
    .i_bubble (1'b0),
    .i_d      (w_memwb_d),
    .o_q      (w_memwb)
  );

  // Fields MEM/WB carries but nobody downstream reads.
  logic [12:0] w_memwb_unused;
  assign w_memwb_unused = {w_memwb.rs1, w_memwb.rs2, w_memwb.MemRead, w_memwb.ALUOp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret   <= '0;
      r_stall_cnt <= '0;
    end else if (!freeze) begin
      if (w_memwb.valid) begin
        r_instret <= r_instret + INSTRET_W'(1);
      end
      // A stall coinciding with a flush is absorbed by the flush bubble.
      if (stall && !flush && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
    end
  end

  assign idex_valid     = w_idex.valid;
  assign idex_rs1       = w_idex.rs1;
  assign idex_rs2       = w_idex.rs2;
  assign idex_rd        = w_idex.rd;
  assign idex_MemRead   = w_idex.MemRead;
  assign idex_RegWrite  = w_idex.RegWrite;
  assign idex_ALUOp     = w_idex.ALUOp;
  assign exmem_valid    = w_exmem.valid;
  assign exmem_rd       = w_exmem.rd;
  assign exmem_RegWrite = w_exmem.RegWrite;
  assign exmem_MemRead  = w_exmem.MemRead;
  assign memwb_valid    = w_memwb.valid;
  assign memwb_rd       = w_memwb.rd;
  assign memwb_RegWrite = w_memwb.RegWrite;
  assign instret        = r_instret;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_track.sv
// Scoreboard bench for pipe_ctrl_track: a history-of-captures reference model
// predicts every stage and counter; a narrow second instance exercises wrap/saturation.
module tb_pipe_ctrl_track;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid, id_RegWrite, id_MemRead, stall, flush, freeze;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_ALUOp;

  logic        idex_valid, idex_MemRead, idex_RegWrite;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [1:0]  idex_ALUOp;
  logic        exmem_valid, exmem_RegWrite, exmem_MemRead;
  logic [4:0]  exmem_rd;
  logic        memwb_valid, memwb_RegWrite;
  logic [4:0]  memwb_rd;
  logic [31:0] instret;
  logic [15:0] stall_cnt;

  logic        s_idex_valid, s_idex_MemRead, s_idex_RegWrite;
  logic [4:0]  s_idex_rs1, s_idex_rs2, s_idex_rd;
  logic [1:0]  s_idex_ALUOp;
  logic        s_exmem_valid, s_exmem_RegWrite, s_exmem_MemRead;
  logic [4:0]  s_exmem_rd;
  logic        s_memwb_valid, s_memwb_RegWrite;
  logic [4:0]  s_memwb_rd;
  logic [3:0]  s_instret;
  logic [3:0]  s_stall_cnt;

  pipe_ctrl_track dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_ALUOp(id_ALUOp),
    .stall(stall), .flush(flush), .freeze(freeze),
    .idex_valid(idex_valid), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_MemRead(idex_MemRead), .idex_RegWrite(idex_RegWrite), .idex_ALUOp(idex_ALUOp),
    .exmem_valid(exmem_valid), .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_RegWrite),
    .exmem_MemRead(exmem_MemRead), .memwb_valid(memwb_valid), .memwb_rd(memwb_rd),
    .memwb_RegWrite(memwb_RegWrite), .instret(instret), .stall_cnt(stall_cnt)
  );

  pipe_ctrl_track #(.INSTRET_W(4), .STALL_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_ALUOp(id_ALUOp),
    .stall(stall), .flush(flush), .freeze(freeze),
    .idex_valid(s_idex_valid), .idex_rs1(s_idex_rs1), .idex_rs2(s_idex_rs2), .idex_rd(s_idex_rd),
    .idex_MemRead(s_idex_MemRead), .idex_RegWrite(s_idex_RegWrite), .idex_ALUOp(s_idex_ALUOp),
    .exmem_valid(s_exmem_valid), .exmem_rd(s_exmem_rd), .exmem_RegWrite(s_exmem_RegWrite),
    .exmem_MemRead(s_exmem_MemRead), .memwb_valid(s_memwb_valid), .memwb_rd(s_memwb_rd),
    .memwb_RegWrite(s_memwb_RegWrite), .instret(s_instret), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    ctrl_t   idex;
    ctrl_t   exmem;
    ctrl_t   memwb;
    longint  retired;
    longint  stalls;
  } exp_t;

  exp_t   sb[$];
  ctrl_t  hist[$];      // every ID/EX capture since reset, oldest first
  longint retired;
  longint stalls_tot;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t stage_back(input int back);
    int idx;
    idx = hist.size() - 1 - back;
    if (idx >= 0) return hist[idx];
    return CTRL_BUBBLE;
  endfunction

  // Apply the current inputs to the model for the coming edge and queue the result.
  task automatic model_step();
    ctrl_t e;
    exp_t  x;
    if (!freeze) begin
      e = CTRL_BUBBLE;
      if (id_valid && !flush && !stall) begin
        e.valid    = 1'b1;
        e.rs1      = id_rs1;
        e.rs2      = id_rs2;
        e.rd       = id_rd;
        e.RegWrite = id_RegWrite && (id_rd != 5'd0);
        e.MemRead  = id_MemRead;
        e.ALUOp    = id_ALUOp;
      end
      hist.push_back(e);
      if (hist.size() >= 4 && hist[hist.size() - 4].valid) retired++;
      if (stall && !flush) stalls_tot++;
    end
    x.idex    = stage_back(0);
    x.exmem   = stage_back(1);
    x.memwb   = stage_back(2);
    x.retired = retired;
    x.stalls  = stalls_tot;
    sb.push_back(x);
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [1:0] alu, input logic stl, input logic fl, input logic frz);
    @(negedge clk);
    rst_n = 1'b1;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_RegWrite = rw; id_MemRead = mr; id_ALUOp = alu;
    stall = stl; flush = fl; freeze = frz;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " idex"}, {idex_valid, idex_rs1, idex_rs2, idex_rd, idex_MemRead, idex_RegWrite, idex_ALUOp}, 64'd0);
    check({tag, " exmem"}, {exmem_valid, exmem_rd, exmem_RegWrite, exmem_MemRead}, 64'd0);
    check({tag, " memwb"}, {memwb_valid, memwb_rd, memwb_RegWrite}, 64'd0);
    check({tag, " instret"}, instret, 64'd0);
    check({tag, " stall_cnt"}, stall_cnt, 64'd0);
    check({tag, " small counters"}, {s_instret, s_stall_cnt}, 64'd0);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    hist.delete();
    retired = 0;
    stalls_tot = 0;
    @(posedge clk);
    #1 check_all_zero("reset held over edge");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("idex_valid", idex_valid, e.idex.valid);
        check("idex_rs1", idex_rs1, e.idex.rs1);
        check("idex_rs2", idex_rs2, e.idex.rs2);
        check("idex_rd", idex_rd, e.idex.rd);
        check("idex_RegWrite", idex_RegWrite, e.idex.RegWrite);
        check("idex_MemRead", idex_MemRead, e.idex.MemRead);
        check("idex_ALUOp", idex_ALUOp, e.idex.ALUOp);
        check("exmem_valid", exmem_valid, e.exmem.valid);
        check("exmem_rd", exmem_rd, e.exmem.rd);
        check("exmem_RegWrite", exmem_RegWrite, e.exmem.RegWrite);
        check("exmem_MemRead", exmem_MemRead, e.exmem.MemRead);
        check("memwb_valid", memwb_valid, e.memwb.valid);
        check("memwb_rd", memwb_rd, e.memwb.rd);
        check("memwb_RegWrite", memwb_RegWrite, e.memwb.RegWrite);
        check("instret", instret, e.retired % 64'h1_0000_0000);
        check("stall_cnt", stall_cnt, (e.stalls > 65535) ? 64'd65535 : e.stalls);
        check("instret 4b wrap", s_instret, e.retired % 16);
        check("stall_cnt 4b sat", s_stall_cnt, (e.stalls > 15) ? 64'd15 : e.stalls);
      end
    end
  end

  initial begin : driver
    retired = 0;
    stalls_tot = 0;
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_RegWrite = 1'b0; id_MemRead = 1'b0; id_ALUOp = 2'b00;
    stall = 1'b0; flush = 1'b0; freeze = 1'b0;
    #2 check_all_zero("power-on reset");
    @(posedge clk);

    // add x5,x1,x2 then addi x6,x5,4
    issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, ALUOP_ITYPE, 1'b0, 1'b0, 1'b0);
    idle(4);

    // lw x7 ; dependent add stalled one cycle then captured
    issue(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, ALUOP_ADD, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, ALUOP_RTYPE, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);
    idle(3);

    // flush together with stall: one uncounted bubble
    issue(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 5'd9, 5'd4, 5'd10, 1'b1, 1'b0, ALUOP_RTYPE, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b0, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);

    // fill all stages, freeze 3 cycles with stall/flush asserted, then resume
    issue(1'b1, 5'd14, 5'd15, 5'd16, 1'b1, 1'b1, ALUOP_ADD, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 5'd17, 5'd18, 5'd19, 1'b1, 1'b0, ALUOP_ITYPE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      issue(1'b1, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0, ALUOP_BRANCH, 1'b1, i[0], 1'b1);
    issue(1'b1, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0, ALUOP_BRANCH, 1'b0, 1'b0, 1'b0);

    // rd=0 with RegWrite=1 is normalised away
    issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);
    idle(3);

    // reset mid-stream with every stage valid
    issue(1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0, ALUOP_ITYPE, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, ALUOP_ITYPE, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, ALUOP_ITYPE, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      issue(($urandom_range(0, 9) < 8),
            5'($urandom), 5'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0));
    end
    idle(5);

    @(posedge clk);
    #5;
    check("scoreboard drained", sb.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_track.md
# pipe_ctrl_track

Pipeline control tracker for the RV32I 5-stage core: carries each decoded instruction's register indices and control bits through the ID/EX, EX/MEM and MEM/WB stage registers. It is the producer side of the hazard/forwarding interface: it consumes the load-use `stall` and the branch `flush`, inserts bubbles, and drives the `idex_*`, `exmem_*` and `memwb_*` signals read by the forwarding and hazard-detection logic. It also keeps retired-instruction and stall-bubble counters.

## Interface
- `INSTRET_W`, 32: width of the retired-instruction counter; wraps modulo 2^INSTRET_W.
- `STALL_W`, 16: width of the stall-bubble counter; saturates at all-ones.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  decoded register indices.
- `id_RegWrite`, `id_MemRead`  in  1 each  decoded control bits.
- `id_ALUOp`  in  2  decoded ALU op class; 2'b11 = I-type.
- `stall`  in  1  load-use stall from hazard detection.
- `flush`  in  1  taken branch resolved in EX; kill the instruction entering ID/EX.
- `freeze`  in  1  memory wait; hold every stage register and counter.
- `idex_valid`, `idex_rs1`, `idex_rs2`, `idex_rd`, `idex_MemRead`, `idex_RegWrite`, `idex_ALUOp`  out  1/5/5/5/1/1/2  ID/EX stage contents.
- `exmem_valid`, `exmem_rd`, `exmem_RegWrite`, `exmem_MemRead`  out  1/5/1/1  EX/MEM stage contents.
- `memwb_valid`, `memwb_rd`, `memwb_RegWrite`  out  1/5/1  MEM/WB stage contents.
- `instret`  out  INSTRET_W  retired-instruction count.
- `stall_cnt`  out  STALL_W  number of load-use bubbles inserted.

## Operation
- Bubble: valid=0, rs1=rs2=rd=0, RegWrite=0, MemRead=0, ALUOp=2'b00.
- Priority per cycle: `freeze` > `flush` > `stall` > normal advance.
- `freeze`=1: all stage registers and both counters hold. `stall` and `flush` are ignored that cycle and must be held by their sources.
- Otherwise MEM/WB ← EX/MEM and EX/MEM ← ID/EX, always; a stall never blocks the later stages.
- ID/EX ← bubble if `flush`, `stall` or `!id_valid`; otherwise ID/EX ← ID fields.
- RegWrite normalization at capture: `idex_RegWrite` = `id_RegWrite` & (`id_rd` != 0). No stage ever shows RegWrite=1 with rd=0.
- MemRead is carried only through ID/EX and EX/MEM; MEM/WB has no MemRead.
- `instret` += 1 when `memwb_valid`=1 and `freeze`=0. This counts the instruction leaving WB.
- `stall_cnt` += 1 when `stall`=1, `flush`=0 and `freeze`=0; it holds at 2^STALL_W−1.
- Reset (`rst_n`=0, any time, including mid-freeze): every stage register becomes a bubble, both counters become 0, and all outputs are 0. Operation restarts on the first rising edge after deassertion.

## Timing
- Every output is registered directly from a flop, with no combinational path from any input to any output.
- Latency: an ID instruction appears on `idex_*` 1 cycle after capture, on `exmem_*` after 2, on `memwb_*` after 3, and counts in `instret` on the 4th edge after capture, absent freezes.
- A stall asserted in cycle N places a bubble on `idex_*` after edge N. The stalled instruction is re-presented by IF/ID in cycle N+1 and captured then if `stall`=0.
- `flush` and `stall` together produce a single bubble that is not counted in `stall_cnt`.
- Each `freeze` cycle adds exactly 1 cycle to every latency above.

## Structure
- Shared package `pipe_pkg` holds:
  - the `ctrl_t` bundle typedef (valid, rs1, rs2, rd, RegWrite, MemRead, ALUOp);
  - the `CTRL_BUBBLE` constant;
  - the ALUOp encodings (`ALUOP_ITYPE` = 2'b11).
- Sub-module `pipe_stage_reg`: one `ctrl_t` register with async active-low reset to `CTRL_BUBBLE`, plus hold and bubble-insert inputs. Instantiate it three times.
- Counters live in the top module.

## Test plan
- Reset: drive `rst_n`=0 mid-stream with all stages valid → all outputs 0 immediately, without waiting for a clock edge; `instret`=0.
- Straight-line flow: issue `add x5,x1,x2` then `addi x6,x5,4` (rd=6, ALUOp=2'b11) → `exmem_rd`=5 with `exmem_RegWrite`=1 in the same cycle `idex_rs1`=5; `instret`=2 four edges after the second capture.
- Load-use: `lw x7` followed by `stall`=1 for one cycle → `idex_valid`=0 for exactly 1 cycle; `stall_cnt`=1; `exmem_MemRead`=1 and `exmem_rd`=7 in the bubble cycle.
- Flush together with stall: both high for one cycle → one bubble and `stall_cnt` unchanged.
- Freeze: hold `freeze`=1 for 3 cycles with valid instructions in all stages → all outputs and `instret` constant; the pipeline resumes intact.
- Boundaries: `id_rd`=0 with `id_RegWrite`=1 → `idex_RegWrite`=0. Preload `stall_cnt`=16'hFFFF, then stall → stays 16'hFFFF. `instret`=32'hFFFFFFFF, then retire → wraps to 0.
